// File: rtl/shared_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_port_arbiter
// Brief    : Round-robin arbiter sharing one registered valid/ready output
//            port among NUM_REQ burst requesters, with a default idle value.
// Revision : 1.0
// ============================================================================
module shared_port_arbiter #(
    parameter int                   NUM_REQ       = 4,
    parameter int                   IN_WIDTH      = 7,
    parameter int                   OUT_WIDTH     = 8,
    parameter logic [OUT_WIDTH-1:0] DEFAULT_VALUE = 8'h7b,
    parameter int                   MAX_BURST     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*IN_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          out_valid,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_src,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int                c_idx_w     = $clog2(NUM_REQ);
    localparam int                c_cnt_w     = 4;
    localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_owner;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_cnt_w-1:0]   r_burst_cnt;

    logic [c_idx_w:0]     w_cand;
    logic [c_idx_w-1:0]   w_pick;
    logic                 w_any;
    logic [IN_WIDTH-1:0]  w_sel_data;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [OUT_WIDTH-1:0] w_adapt;
    logic                 w_free;
    logic                 w_xfer;
    logic                 w_release;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic [c_idx_w-1:0]   w_next_ptr;

    // Circular search starting at r_rr_ptr; first valid index wins.
    always_comb begin
        w_cand = '0;
        w_pick = '0;
        w_any  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (c_idx_w+1)'(k);
            if (w_cand >= (c_idx_w+1)'(NUM_REQ)) begin
                w_cand = w_cand - (c_idx_w+1)'(NUM_REQ);
            end
            if (!w_any && req_valid[w_cand[c_idx_w-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_cand[c_idx_w-1:0];
            end
        end
    end

    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == c_idx_w'(i)) begin
                w_sel_data  = req_data[i*IN_WIDTH +: IN_WIDTH];
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
            end
        end
    end

    generate
        if (IN_WIDTH < OUT_WIDTH) begin : g_zext
            assign w_adapt = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, w_sel_data};
        end else if (IN_WIDTH > OUT_WIDTH) begin : g_trunc
            assign w_adapt = w_sel_data[OUT_WIDTH-1:0];
        end else begin : g_pass
            assign w_adapt = w_sel_data;
        end
    endgenerate

    // grant is all-zero outside GRANT, so this also forces req_ready low in IDLE.
    assign w_free     = !out_valid || out_ready;
    assign req_ready  = grant & {NUM_REQ{w_free}};
    assign busy       = (r_state == S_GRANT);

    assign w_xfer     = (r_state == S_GRANT) && w_sel_valid && w_free;
    assign w_cnt_inc  = r_burst_cnt + c_cnt_w'(1);
    assign w_release  = (r_state == S_GRANT) &&
                        (!w_sel_valid || (w_xfer && (w_sel_last || (w_cnt_inc == c_max_burst))));
    assign w_next_ptr = (r_owner == c_idx_w'(NUM_REQ-1)) ? '0 : r_owner + c_idx_w'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            grant       <= '0;
            out_valid   <= 1'b0;
            out_data    <= DEFAULT_VALUE;
            out_src     <= '0;
        end else begin
            // Output register: a new beat may replace an accepted one in the same cycle.
            if (w_xfer) begin
                out_valid <= 1'b1;
                out_data  <= w_adapt;
                out_src   <= r_owner;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_data  <= DEFAULT_VALUE;
            end

            if (r_state == S_IDLE) begin
                if (w_any) begin
                    r_state     <= S_GRANT;
                    r_owner     <= w_pick;
                    grant       <= NUM_REQ'(1) << w_pick;
                    r_burst_cnt <= '0;
                end
            end else begin
                if (w_release) begin
                    r_state     <= S_IDLE;
                    grant       <= '0;
                    r_rr_ptr    <= w_next_ptr;
                    r_burst_cnt <= '0;
                end else if (w_xfer) begin
                    r_burst_cnt <= w_cnt_inc;
                end
            end
        end
    end

endmodule
`default_nettype wire
